sr_pulse_driver: RTL
====================

# sr_pulse_driver

Transmit-side companion to the clocked SR latch. Accepts target-level requests over a valid/ready handshake and converts each one into a clean set or reset pulse of programmable width on `s`/`r`, followed by a programmable quiet gap. The block tracks the latch state it has commanded, so redundant requests produce no pulse. It never drives the forbidden `s=r=1` combination. It sits between control logic and an `sr_latch` instance, with the latch `q` optionally fed back for checking.

## Interface
Parameters:
- `PULSE_W`, default 2: cycles `s` or `r` is held high per command; legal range ≥ 1.
- `GAP_W`, default 1: cycles with both `s` and `r` low after a pulse, before the next request is accepted; legal range ≥ 0.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_valid`, input, 1: request present.
- `req_val`, input, 1: target latch level (1 = set, 0 = reset).
- `req_ready`, output, 1: block can accept a request.
- `s`, output, 1: set command to latch.
- `r`, output, 1: reset command to latch.
- `q_fb`, input, 1: latch `q` feedback; used only under the configuration macro.
- `busy`, output, 1: high in PULSE or GAP.
- `q_track`, output, 1: level last commanded.
- `err`, output, 1: sticky feedback mismatch flag.

## Operation
- Asserting `rst` takes effect immediately, without waiting for a clock edge, including mid-pulse.
- Reset values: state = IDLE, `s`=0, `r`=0, `busy`=0, `q_track`=0, `err`=0, `req_ready`=1.
- The internal counter width is `$clog2(max(PULSE_W,GAP_W)+1)`. The counter loads `PULSE_W-1` on entering PULSE and `GAP_W-1` on entering GAP.

State machine:
- IDLE: `req_ready`=1. A request is accepted on the rising edge where `req_valid && req_ready` is true.
  - Accepted with `req_val == q_track`: no pulse is issued and the state stays IDLE. The request is consumed in one cycle.
  - Accepted with `req_val != q_track`: go to PULSE and set `q_track <= req_val`.
- PULSE: `s = q_track`, `r = ~q_track` (registered outputs), `req_ready`=0. Stays for exactly `PULSE_W` cycles. Then goes to GAP, or to IDLE if `GAP_W` = 0.
- GAP: `s`=`r`=0, `req_ready`=0. Stays for exactly `GAP_W` cycles, then goes to IDLE.

Invariants and boundary cases:
- Invariant: `s & r` is never 1, including across reset and back-to-back requests.
- `req_val` is sampled only at acceptance. Changes while busy are ignored, and the request is held off by `req_ready`=0.
- Back-to-back opposite requests with `GAP_W`=0: the `s` pulse is followed by the `r` pulse after exactly one IDLE cycle in which both are 0.
- Reset mid-PULSE: `s`/`r` drop immediately and `q_track` returns to 0, matching the latch's own reset value.

## Timing
- Acceptance edge T: `s`/`r` are high during cycles T+1 … T+PULSE_W.
- Gap: cycles T+PULSE_W+1 … T+PULSE_W+GAP_W.
- `req_ready` rises in cycle T+PULSE_W+GAP_W+1.
- Worst-case throughput is one level change per `PULSE_W+GAP_W+1` cycles. A redundant request costs one cycle.
- `busy` equals `~req_ready`. All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SR_FEEDBACK_CHECK_EN` defined:
  - On the first rising edge after `s`/`r` return to 0 following a pulse, `q_fb` is compared with `q_track`.
  - A mismatch sets `err`=1, and `err` stays high until `rst`.
  - The check is pending-flag based, so it also works when `GAP_W`=0.
- `SR_FEEDBACK_CHECK_EN` undefined: `q_fb` is ignored and `err` is tied to 0. FSM timing is identical in both builds.

## Test plan
Bench settings are `PULSE_W`=2, `GAP_W`=1 unless stated otherwise.
- Reset, then a request with `req_val`=1: `s`=1 for exactly 2 cycles, then 1 gap cycle, then `req_ready`=1. `q_track`=1, and `r` stays 0 throughout.
- With `q_track`=1, request `req_val`=1: no pulse, `req_ready` stays 1, and the next request is accepted on the following edge.
- Alternating requests 1, 0, 1 held valid continuously: `s`, `r`, `s` pulses spaced 4 cycles apart. `s&r` is never 1, checked every cycle.
- Assert `rst` during the second `s` cycle: `s` drops to 0 before the next edge, and `q_track`=0, `err`=0, `req_ready`=1.
- `PULSE_W`=1, `GAP_W`=0, requests 1 then 0: `s` for 1 cycle, 1 idle cycle, `r` for 1 cycle.
- With `SR_FEEDBACK_CHECK_EN` and the connected `sr_latch`: `err` stays 0. With `q_fb` forced to 0 and request 1: `err`=1 one cycle after `s` falls, and it holds until `rst`.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// Converts level requests into set/reset pulses of PULSE_W cycles followed by a GAP_W quiet gap.
// Optional q_fb check against the commanded level is enabled by defining SR_FEEDBACK_CHECK_EN.
module sr_pulse_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic q_track,
  output logic err
);

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Main FSM; every output is a register so s and r can never glitch high together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      q_track   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready && (req_val != q_track)) begin
            state_r   <= PULSE;
            cnt_r     <= PULSE_LD;
            q_track   <= req_val;
            s         <= req_val;
            r         <= ~req_val;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_r == '0) begin
            s <= 1'b0;
            r <= 1'b0;
            if (GAP_W == 0) begin
              state_r   <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_r <= GAP;
              cnt_r   <= GAP_LD;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_r == '0) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          s         <= 1'b0;
          r         <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SR_FEEDBACK_CHECK_EN
  logic pend_r;

  // One edge after a pulse ends the latch must already show the commanded level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= 1'b0;
      err    <= 1'b0;
    end else begin
      pend_r <= (state_r == PULSE) && (cnt_r == '0);
      if (pend_r && (q_fb != q_track)) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;

  // Feedback checking disabled: err is a constant-zero register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= 1'b0;
    end
  end
`endif

endmodule
